// File: rtl/bus2_line_master_if.sv
// Cache-side request/response handshake for bus2_line_master.
// The cache core is the master; the line master block is the slave.
interface bus2_line_master_if #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int LINE_BITS      = 128
) ();
  logic                      req_valid;
  logic                      req_write;
  logic [ADDR2_BUS_SIZE-1:0] req_addr;
  logic [LINE_BITS-1:0]      req_wdata;
  logic                      req_ready;
  logic                      done;
  logic                      err;
  logic [LINE_BITS-1:0]      rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, done, err, rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, done, err, rdata
  );
endinterface

// File: rtl/bus2_line_master.sv
// bus2 cache-side initiator: issues one READ_LINE/WRITE_LINE at a time on the
// shared tri-state A2/D2/C2 wires and reports completion back to the cache.
module bus2_line_master #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BITS      = 128,
  parameter int TIMEOUT        = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  inout  wire  [ADDR2_BUS_SIZE-1:0] A2_WIRE,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE,
  bus2_line_master_if.slave         i_cache
);

  localparam int BEATS = LINE_BITS / DATA2_BUS_SIZE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RECV   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]                r_state;
  logic [ADDR2_BUS_SIZE-1:0] r_addr;
  logic [LINE_BITS-1:0]      r_wdata;
  logic                      r_write;
  logic [BW-1:0]             r_beat;
  logic [TW-1:0]             r_wait;
  logic                      r_err;
  logic [LINE_BITS-1:0]      r_rdata;

  logic                 w_own;
  logic                 w_resp;
  logic                 w_capture;
  logic [LINE_BITS-1:0] w_line;

  assign w_own     = (r_state == S_SEND);
  assign w_resp    = (C2_WIRE == C2_RESPONSE);
  assign w_capture = w_resp && ((r_state == S_WAIT && !r_write) || r_state == S_RECV);

  // Bus ownership is purely a function of state, so an async reset releases
  // the wires in the same cycle it is asserted.
  assign A2_WIRE = w_own ? r_addr : {ADDR2_BUS_SIZE{1'bz}};
  assign D2_WIRE = (w_own && r_write) ? r_wdata[DATA2_BUS_SIZE-1:0] : {DATA2_BUS_SIZE{1'bz}};
  assign C2_WIRE = w_own ? (r_write ? C2_WRITE_LINE : C2_READ_LINE) : {CTR2_BUS_SIZE{1'bz}};

  assign i_cache.req_ready = (r_state == S_IDLE);
  assign i_cache.done      = (r_state == S_FINISH);
  assign i_cache.err       = (r_state == S_FINISH) && r_err;
  assign i_cache.rdata     = r_rdata;

  // Read beats land in a shadow shifter; rdata only sees a fully received line,
  // so a truncated burst leaves the previous line intact.
  if (BEATS > 1) begin : g_shadow
    logic [LINE_BITS-DATA2_BUS_SIZE-1:0] r_shadow;

    assign w_line = {D2_WIRE, r_shadow};

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_shadow <= '0;
      end else if (w_capture) begin
        r_shadow <= w_line[LINE_BITS-1:DATA2_BUS_SIZE];
      end
    end
  end else begin : g_single
    assign w_line = D2_WIRE;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cache.req_valid) begin
            r_addr  <= i_cache.req_addr;
            r_wdata <= i_cache.req_wdata;
            r_write <= i_cache.req_write;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!r_write || r_beat == BEAT_LAST) begin
            r_beat  <= '0;
            r_wait  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_beat  <= r_beat + BW'(1);
            r_wdata <= r_wdata >> DATA2_BUS_SIZE;
          end
        end
        S_WAIT: begin
          // A response on the same edge as the timeout still wins.
          if (w_resp) begin
            if (r_write) begin
              r_err   <= 1'b0;
              r_state <= S_FINISH;
            end else if (BEATS == 1) begin
              r_rdata <= w_line;
              r_err   <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_beat  <= BW'(1);
              r_state <= S_RECV;
            end
          end else if (TIMEOUT != 0 && r_wait == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end
        S_RECV: begin
          if (w_resp) begin
            if (r_beat == BEAT_LAST) begin
              r_rdata <= w_line;
              r_err   <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end else begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
